// File: rtl/conv_loader_pkg.sv
// Shared types for the convolution input loader.
//   loader_state_e : load sequencing FSM states
package conv_loader_pkg;

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_LOAD_W = 2'd1,
        S_LOAD_X = 2'd2,
        S_DONE   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/counter_with_clr.sv
// Clearable up-counter used as a memory address generator.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset
//   incr_i   : advance count by one
//   clr_i    : return count to zero (wins over incr_i)
//   count_o  : current count
module counter_with_clr #(
    parameter int OUTW = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            incr_i,
    input  logic            clr_i,
    output logic [OUTW-1:0] count_o
);

    logic [OUTW-1:0] count_q;
    logic [OUTW-1:0] count_d;

    // The last beat of a matrix both writes and clears; clearing must win
    // so the next set starts at address 0.
    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (incr_i)
            count_d = count_q + OUTW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/conv_input_loader.sv
// Streams a kernel (optional) and an input matrix into two write ports.
// A set is either K*K kernel elements followed by R*R input elements
// (new_W=1 on the first beat) or only R*R input elements (new_W=0), after
// which the loader holds until the compute engine pulses compute_finished.
//
// State table:
//   S_START  | idle, first beat of a set selects kernel or input load
//   S_LOAD_W | writing kernel elements W[1..K*K-1]
//   S_LOAD_X | writing input elements X[..R*R-1]
//   S_DONE   | set complete, buffers held for compute, no beats accepted
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   INPUT_TDATA/TVALID/TREADY     : element stream handshake
//   new_W                         : first-beat qualifier (1 = kernel follows)
//   X_wr_addr/X_wr_data/X_wr_en   : input-matrix memory write port
//   W_wr_addr/W_wr_data/W_wr_en   : kernel memory write port
//   inputs_loaded                 : high while the set is held in S_DONE
//   compute_finished              : pulse releasing the buffers
module conv_input_loader
    import conv_loader_pkg::*;
#(
    parameter  int INW = 8,
    parameter  int R   = 9,
    parameter  int K   = 4,
    localparam int XAW = $clog2(R*R),
    localparam int WAW = $clog2(K*K)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [INW-1:0] INPUT_TDATA,
    input  logic           INPUT_TVALID,
    input  logic           new_W,
    output logic           INPUT_TREADY,
    output logic [XAW-1:0] X_wr_addr,
    output logic [INW-1:0] X_wr_data,
    output logic           X_wr_en,
    output logic [WAW-1:0] W_wr_addr,
    output logic [INW-1:0] W_wr_data,
    output logic           W_wr_en,
    output logic           inputs_loaded,
    input  logic           compute_finished
);

    loader_state_e  state_q;
    logic           ready_q;
    logic           loaded_q;
    logic           accept;
    logic           w_last;
    logic           x_last;
    logic           w_clr;
    logic           x_clr;
    logic [WAW-1:0] w_cnt;
    logic [XAW-1:0] x_cnt;

    // Reset gates the write strobes so a beat presented during reset
    // never reaches the memories.
    assign accept = INPUT_TVALID & ready_q & ~reset;

    assign w_last = (w_cnt == WAW'(K*K - 1));
    assign x_last = (x_cnt == XAW'(R*R - 1));

    assign W_wr_en = accept & (((state_q == S_START) & new_W) | (state_q == S_LOAD_W));
    assign X_wr_en = accept & (((state_q == S_START) & ~new_W) | (state_q == S_LOAD_X));

    assign w_clr = W_wr_en & w_last;
    assign x_clr = X_wr_en & x_last;

    assign W_wr_addr = w_cnt;
    assign X_wr_addr = x_cnt;
    assign W_wr_data = INPUT_TDATA;
    assign X_wr_data = INPUT_TDATA;

    assign INPUT_TREADY  = ready_q;
    assign inputs_loaded = loaded_q;

    counter_with_clr #(.OUTW(WAW)) u_w_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .incr_i  (W_wr_en),
        .clr_i   (w_clr),
        .count_o (w_cnt)
    );

    counter_with_clr #(.OUTW(XAW)) u_x_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .incr_i  (X_wr_en),
        .clr_i   (x_clr),
        .count_o (x_cnt)
    );

    // ready/loaded are registered alongside the state so neither has a
    // combinational path from the stream inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_START;
            ready_q  <= 1'b1;
            loaded_q <= 1'b0;
        end else begin
            case (state_q)
                S_START: begin
                    if (accept)
                        state_q <= new_W ? S_LOAD_W : S_LOAD_X;
                end
                S_LOAD_W: begin
                    if (w_clr)
                        state_q <= S_LOAD_X;
                end
                S_LOAD_X: begin
                    if (x_clr) begin
                        state_q  <= S_DONE;
                        ready_q  <= 1'b0;
                        loaded_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (compute_finished) begin
                        state_q  <= S_START;
                        ready_q  <= 1'b1;
                        loaded_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_START;
                    ready_q  <= 1'b1;
                    loaded_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_input_loader.sv
module tb_conv_input_loader;

    localparam int INW = 8;
    localparam int R   = 3;
    localparam int K   = 2;
    localparam int XAW = $clog2(R*R);
    localparam int WAW = $clog2(K*K);
    localparam int KK  = K*K;
    localparam int RR  = R*R;

    logic           clk = 1'b0;
    logic           reset;
    logic [INW-1:0] INPUT_TDATA;
    logic           INPUT_TVALID;
    logic           new_W;
    logic           INPUT_TREADY;
    logic [XAW-1:0] X_wr_addr;
    logic [INW-1:0] X_wr_data;
    logic           X_wr_en;
    logic [WAW-1:0] W_wr_addr;
    logic [INW-1:0] W_wr_data;
    logic           W_wr_en;
    logic           inputs_loaded;
    logic           compute_finished;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    conv_input_loader #(.INW(INW), .R(R), .K(K)) dut (
        .clk              (clk),
        .reset            (reset),
        .INPUT_TDATA      (INPUT_TDATA),
        .INPUT_TVALID     (INPUT_TVALID),
        .new_W            (new_W),
        .INPUT_TREADY     (INPUT_TREADY),
        .X_wr_addr        (X_wr_addr),
        .X_wr_data        (X_wr_data),
        .X_wr_en          (X_wr_en),
        .W_wr_addr        (W_wr_addr),
        .W_wr_data        (W_wr_data),
        .W_wr_en          (W_wr_en),
        .inputs_loaded    (inputs_loaded),
        .compute_finished (compute_finished)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Memories as seen through the DUT write ports.
    logic [INW-1:0] mem_w [KK];
    logic [INW-1:0] mem_x [RR];
    always @(posedge clk) begin
        if (W_wr_en && int'(W_wr_addr) < KK) mem_w[W_wr_addr] <= W_wr_data;
        if (X_wr_en && int'(X_wr_addr) < RR) mem_x[X_wr_addr] <= X_wr_data;
    end

    // Behavioural model: a set is a run of beats counted by p; the first
    // beat fixes whether the first KK beats are kernel elements.
    int p = 0;
    bit done = 1'b0;
    bit set_nw = 1'b0;

    function automatic bit eff_nw();
        return (p == 0) ? bit'(new_W) : set_nw;
    endfunction

    function automatic bit m_acc();
        return INPUT_TVALID && !done && !reset;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            p = 0;
            done = 1'b0;
        end else if (done) begin
            if (compute_finished) done = 1'b0;
        end else if (m_acc()) begin
            if (p == 0) set_nw = new_W;
            p++;
            if (p == (set_nw ? KK + RR : RR)) begin
                p = 0;
                done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit nw;
            bit acc;
            bit ew;
            bit ex;
            int off;
            int ewa;
            int exa;
            nw  = eff_nw();
            acc = m_acc();
            ew  = acc && nw && (p < KK);
            ex  = acc && !(nw && (p < KK));
            off = set_nw ? KK : 0;
            ewa = (!done && p > 0 && set_nw && p < KK) ? p : 0;
            exa = (!done && p > 0 && p >= off) ? p - off : 0;
            check("tready", int'(INPUT_TREADY), int'(!done));
            check("inputs_loaded", int'(inputs_loaded), int'(done));
            check("W_wr_en", int'(W_wr_en), int'(ew));
            check("X_wr_en", int'(X_wr_en), int'(ex));
            check("W_wr_addr", int'(W_wr_addr), ewa);
            check("X_wr_addr", int'(X_wr_addr), exa);
            if (W_wr_en) check("W_wr_data", int'(W_wr_data), int'(INPUT_TDATA));
            if (X_wr_en) check("X_wr_data", int'(X_wr_data), int'(INPUT_TDATA));
        end
    end

    task automatic cyc(input bit v, input int d, input bit nw, input bit cf);
        INPUT_TVALID     = v;
        INPUT_TDATA      = INW'(d);
        new_W            = nw;
        compute_finished = cf;
        @(posedge clk);
        #1;
    endtask

    task automatic check_w(input string name, input int e0, input int e1, input int e2, input int e3);
        check({name, "_W0"}, int'(mem_w[0]), e0);
        check({name, "_W1"}, int'(mem_w[1]), e1);
        check({name, "_W2"}, int'(mem_w[2]), e2);
        check({name, "_W3"}, int'(mem_w[3]), e3);
    endtask

    task automatic check_x_seq(input string name, input int base);
        for (int i = 0; i < RR; i++)
            check($sformatf("%s_X%0d", name, i), int'(mem_x[i]), base + i);
    endtask

    int cnt;
    int seen;

    initial begin
        reset = 1'b1;
        INPUT_TVALID = 1'b0;
        INPUT_TDATA = '0;
        new_W = 1'b0;
        compute_finished = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_tready", int'(INPUT_TREADY), 1);
        check("rst_loaded", int'(inputs_loaded), 0);
        check("rst_waddr", int'(W_wr_addr), 0);
        check("rst_xaddr", int'(X_wr_addr), 0);

        // Kernel + input, back to back; new_W after the first beat is ignored.
        cyc(1, 1, 1, 0);
        for (int d = 2; d <= 13; d++) cyc(1, d, 1'(d % 2), 0);
        check("s1_loaded", int'(inputs_loaded), 1);
        check("s1_tready", int'(INPUT_TREADY), 0);
        check_w("s1", 1, 2, 3, 4);
        check_x_seq("s1", 5);
        cyc(0, 0, 0, 1);

        // Input only; kernel must stay untouched.
        cyc(1, 20, 0, 0);
        for (int d = 21; d <= 28; d++) cyc(1, d, 1, 0);
        check("s2_loaded", int'(inputs_loaded), 1);
        check_w("s2", 1, 2, 3, 4);
        check_x_seq("s2", 20);

        // Hold in done with valid high, then release.
        for (int i = 0; i < 5; i++) cyc(1, 99, 1, 0);
        check_x_seq("hold", 20);
        check_w("hold", 1, 2, 3, 4);
        cyc(0, 0, 0, 1);
        check("rel_tready", int'(INPUT_TREADY), 1);
        check("rel_loaded", int'(inputs_loaded), 0);

        // Valid toggling every cycle; count cycles to inputs_loaded.
        cnt = 1;
        seen = 0;
        for (int d = 1; d <= 13; d++) begin
            cyc(1, d, 1'(d == 1), 0);
            cnt++;
            if (inputs_loaded && seen == 0) seen = cnt;
            if (d != 13) begin
                cyc(0, 0, 0, 0);
                cnt++;
                if (inputs_loaded && seen == 0) seen = cnt;
            end
        end
        check("toggle_cycles", seen, 26);
        check_w("tog", 1, 2, 3, 4);
        check_x_seq("tog", 5);
        cyc(0, 0, 0, 1);

        // Reset after the 6th beat, with a beat presented during reset.
        cyc(1, 31, 1, 0);
        for (int d = 32; d <= 36; d++) cyc(1, d, 0, 0);
        reset = 1'b1;
        cyc(1, 77, 0, 0);
        reset = 1'b0;
        check("mrst_tready", int'(INPUT_TREADY), 1);
        check("mrst_loaded", int'(inputs_loaded), 0);
        check("mrst_waddr", int'(W_wr_addr), 0);
        check("mrst_xaddr", int'(X_wr_addr), 0);
        check_w("mrst", 31, 32, 33, 34);
        check("mrst_X0", int'(mem_x[0]), 35);
        check("mrst_X1", int'(mem_x[1]), 36);
        check("mrst_X2", int'(mem_x[2]), 7);
        cyc(1, 41, 1, 0);
        for (int d = 42; d <= 53; d++) cyc(1, d, 0, 0);
        check("s4_loaded", int'(inputs_loaded), 1);
        check_w("s4", 41, 42, 43, 44);
        check_x_seq("s4", 45);
        cyc(0, 0, 0, 1);

        // compute_finished during input load is ignored.
        for (int d = 60; d <= 68; d++) cyc(1, d, 0, 1'(d == 62));
        check("s5_loaded", int'(inputs_loaded), 1);
        check_x_seq("s5", 60);
        check_w("s5", 41, 42, 43, 44);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
